moore_seq_det: RTL and testbench

Parametrised Moore-style serial sequence detector. Generalises the fixed zero detector to any bit pattern of LEN bits. Adds run-time overlap/non-overlap mode, an input-valid qualifier and a saturating match counter with synchronous clear. Sits on a 1-bit serial input stream; its registered outputs feed status/display logic.

---
 rtl/moore_seq_det_pkg.sv | 51 +++++
 rtl/moore_seq_det_sat_counter.sv | 22 ++
 rtl/moore_seq_det.sv | 75 +++++++
 tb/tb_moore_seq_det.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/moore_seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
// The KMP transition table is built entirely from these constant functions.
package moore_seq_det_pkg;

    localparam int MAX_LEN = 16;

    function automatic int state_w(input int len);
        return $clog2(len + 1);
    endfunction

    // pat[len-1] is the first bit of the pattern on the wire
    function automatic int border_len(
        input logic [MAX_LEN-1:0] pat,
        input int                 len
    );
        int   best;
        logic ok;
        best = 0;
        for (int b = 1; b < len; b++) begin
            ok = 1'b1;
            for (int i = 0; i < b; i++)
                if (pat[len-1-i] != pat[b-1-i]) ok = 1'b0;
            if (ok) best = b;
        end
        return best;
    endfunction

    function automatic int next_state(
        input int                 k,
        input logic               bit_in,
        input logic [MAX_LEN-1:0] pat,
        input int                 len
    );
        int   best;
        int   pos;
        logic ok;
        logic s;
        best = 0;
        for (int j = 1; j <= k + 1; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                pos = k + 1 - j + i;
                s   = (pos == k) ? bit_in : pat[len-1-pos];
                if (pat[len-1-i] != s) ok = 1'b0;
            end
            if (ok) best = j;
        end
        return best;
    endfunction

endpackage

// File: rtl/moore_seq_det_sat_counter.sv
// Saturating event counter; a clear on the same edge beats an increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/moore_seq_det.sv
// Moore serial pattern detector with overlap mode, valid qualifier
// and a saturating match counter.
module moore_seq_det
    import moore_seq_det_pkg::*;
#(
    parameter int             LEN     = 3,
    parameter logic [LEN-1:0] PATTERN = LEN'(3'b000),
    parameter int             CNT_W   = 8,
    localparam int            SW      = state_w(LEN)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x_in,
    input  logic             x_valid,
    input  logic             mode_overlap,
    input  logic             clear_cnt,
    output logic             y_out,
    output logic [SW-1:0]    state_out,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [MAX_LEN-1:0] PAT   = MAX_LEN'(PATTERN);
    localparam int                 B     = border_len(PAT, LEN);
    localparam logic [SW-1:0]      S_LEN = SW'(LEN);
    localparam int                 ROWS  = 2 ** SW;

    logic [SW-1:0] tbl0 [ROWS];
    logic [SW-1:0] tbl1 [ROWS];
    logic [SW-1:0] state;
    logic [SW-1:0] src;
    logic [SW-1:0] nxt;
    logic          hit;

    // Rows LEN and above are never selected; S_LEN is remapped to src first
    for (genvar k = 0; k < ROWS; k++) begin : g_row
        if (k < LEN) begin : g_live
            assign tbl0[k] = SW'(next_state(k, 1'b0, PAT, LEN));
            assign tbl1[k] = SW'(next_state(k, 1'b1, PAT, LEN));
        end else begin : g_pad
            assign tbl0[k] = '0;
            assign tbl1[k] = '0;
        end
    end

    always_comb begin
        src = state;
        if (state == S_LEN) src = mode_overlap ? SW'(B) : '0;
        nxt = x_in ? tbl1[src] : tbl0[src];
    end

    assign hit = x_valid && (nxt == S_LEN);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= '0;
            y_out <= 1'b0;
        end else if (x_valid) begin
            state <= nxt;
            y_out <= (nxt == S_LEN);
        end
    end

    assign state_out = state;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clock(clock),
        .reset(reset),
        .inc  (hit),
        .clr  (clear_cnt),
        .cnt  (match_cnt)
    );

endmodule

// File: tb/tb_moore_seq_det.sv
// Three detector configurations driven by one stream and checked against
// a history-based reference model.
module tb_moore_seq_det;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic x_in = 1'b0;
    logic x_valid = 1'b0;
    logic mode_overlap = 1'b1;
    logic clear_cnt = 1'b0;

    logic       y0, y1, y2;
    logic [1:0] st0, st2;
    logic [2:0] st1;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    always #5 clock = ~clock;

    moore_seq_det u_d0 (
        .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid),
        .mode_overlap(mode_overlap), .clear_cnt(clear_cnt),
        .y_out(y0), .state_out(st0), .match_cnt(cnt0)
    );

    moore_seq_det #(.LEN(4), .PATTERN(4'b1010)) u_d1 (
        .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid),
        .mode_overlap(mode_overlap), .clear_cnt(clear_cnt),
        .y_out(y1), .state_out(st1), .match_cnt(cnt1)
    );

    moore_seq_det #(.CNT_W(2)) u_d2 (
        .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid),
        .mode_overlap(mode_overlap), .clear_cnt(clear_cnt),
        .y_out(y2), .state_out(st2), .match_cnt(cnt2)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          m_len [3] = '{3, 4, 3};
    logic [15:0] m_pat [3] = '{16'h0, 16'hA, 16'h0};
    int          m_max [3] = '{255, 255, 3};
    bit          hist  [3][$];
    int          m_st  [3];
    int          m_cnt [3];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Longest suffix of the accepted history that is a pattern prefix
    function automatic int match_len(input int i);
        int  n;
        int  top;
        bit  ok;
        n   = hist[i].size();
        top = (n < m_len[i]) ? n : m_len[i];
        for (int k = top; k >= 1; k--) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++)
                if (hist[i][n-k+j] != m_pat[i][m_len[i]-1-j]) ok = 1'b0;
            if (ok) return k;
        end
        return 0;
    endfunction

    task automatic model_edge(input int i, input bit b, input bit v,
                              input bit m, input bit c);
        if (v) begin
            if (m_st[i] == m_len[i] && !m) hist[i].delete();
            hist[i].push_back(b);
            if (hist[i].size() > m_len[i]) void'(hist[i].pop_front());
            m_st[i] = match_len(i);
        end
        if (c) m_cnt[i] = 0;
        else if (v && m_st[i] == m_len[i] && m_cnt[i] < m_max[i]) m_cnt[i]++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hist[i].delete();
            m_st[i]  = 0;
            m_cnt[i] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_y0"}, int'(y0), int'(m_st[0] == m_len[0]));
        chk({tag, "_s0"}, int'(st0), m_st[0]);
        chk({tag, "_c0"}, int'(cnt0), m_cnt[0]);
        chk({tag, "_y1"}, int'(y1), int'(m_st[1] == m_len[1]));
        chk({tag, "_s1"}, int'(st1), m_st[1]);
        chk({tag, "_c1"}, int'(cnt1), m_cnt[1]);
        chk({tag, "_y2"}, int'(y2), int'(m_st[2] == m_len[2]));
        chk({tag, "_s2"}, int'(st2), m_st[2]);
        chk({tag, "_c2"}, int'(cnt2), m_cnt[2]);
    endtask

    task automatic step(input bit v, input bit b, input bit m, input bit c,
                        input string tag);
        x_valid      = v;
        x_in         = b;
        mode_overlap = m;
        clear_cnt    = c;
        @(posedge clock);
        for (int i = 0; i < 3; i++) model_edge(i, b, v, m, c);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        check_all("por");
        @(negedge clock);
        reset = 1'b1;

        for (int n = 0; n < 4; n++) step(1, 0, 1, 0, "t1");
        chk("t1_cnt", int'(cnt0), 2);
        chk("t1_st", int'(st0), 3);

        do_reset("t2r");
        for (int n = 0; n < 3; n++) step(1, 0, 0, 0, "t2");
        chk("t2_y3", int'(y0), 1);
        step(1, 0, 0, 0, "t2");
        chk("t2_st", int'(st0), 1);
        chk("t2_cnt1", int'(cnt0), 1);
        step(1, 0, 0, 0, "t2");
        step(1, 0, 0, 0, "t2");
        chk("t2_cnt2", int'(cnt0), 2);

        do_reset("t3r");
        foreach (m_len[n]) ;
        for (int n = 0; n < 6; n++) step(1, ~n[0], 1, 0, "t3o");
        chk("t3o_cnt", int'(cnt1), 2);
        do_reset("t3r2");
        for (int n = 0; n < 6; n++) step(1, ~n[0], 0, 0, "t3n");
        chk("t3n_st", int'(st1), 2);
        chk("t3n_cnt", int'(cnt1), 1);

        do_reset("t4r");
        step(1, 0, 1, 0, "t4");
        step(1, 0, 1, 0, "t4");
        for (int n = 0; n < 3; n++) begin
            step(0, 1, 1, 0, "t4g");
            chk("t4_hold", int'(st0), 2);
        end
        step(1, 0, 1, 0, "t4");
        step(0, 0, 1, 0, "t4h");
        step(0, 1, 1, 0, "t4h");
        chk("t4_yhold", int'(y0), 1);
        chk("t4_cnt", int'(cnt0), 1);

        do_reset("t5r");
        for (int n = 0; n < 7; n++) step(1, 0, 1, 0, "t5");
        chk("t5_sat", int'(cnt2), 3);
        step(1, 0, 1, 1, "t5c");
        chk("t5_clr", int'(cnt2), 0);
        chk("t5_y", int'(y2), 1);

        do_reset("t6r");
        step(1, 0, 1, 0, "t6");
        step(1, 0, 1, 0, "t6");
        do_reset("t6mid");
        step(1, 0, 1, 0, "t6");
        step(1, 0, 1, 0, "t6");
        chk("t6_nodet", int'(y0), 0);
        step(1, 0, 1, 0, "t6");
        chk("t6_det", int'(y0), 1);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset("rnd_rst");
            end else begin
                step($urandom_range(0, 3) != 0, 1'($urandom),
                     $urandom_range(0, 7) != 0, $urandom_range(0, 24) == 0,
                     "rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
